comp_reset_sequencer: RTL and testbench

Multi-channel, runtime-programmable successor to the single-channel comparator reset generator in the rangefinder front end. For each of N_CH asynchronous comparator outputs, it synchronises the rising edge into ref_clk. It then waits a programmable delay and drives an active-low reset pulse of programmable width. A programmable holdoff (blanking) window follows each pulse. Optional retrigger during the delay, per-channel enable and sticky overrun flags are included for firmware diagnostics.

---
 rtl/comp_rst_pkg.sv | 20 ++
 rtl/comp_reset_channel.sv | 148 ++++++++++++++
 rtl/comp_reset_sequencer.sv | 42 ++++
 tb/tb_comp_reset_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_rst_pkg.sv
// Shared definitions for the comparator reset sequencer: channel state
// encoding and the zero-to-one count clamp used for delay and width.
package comp_rst_pkg;

  // Widest count the clamp helper handles; channels cast to/from CNT_W.
  localparam int CNT_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } ch_state_t;

  // A count of zero would mean "no cycles" for delay/width; treat it as one.
  function automatic logic [CNT_W_MAX-1:0] clampZero(input logic [CNT_W_MAX-1:0] value);
    clampZero = (value == '0) ? CNT_W_MAX'(1) : value;
  endfunction

endpackage

// File: rtl/comp_reset_channel.sv
// One comparator channel: synchroniser, rising-edge detect, sequencing FSM
// (IDLE -> DELAY -> ACTIVE -> HOLDOFF), config latches, and the registered
// active-low reset pulse, busy and sticky overrun outputs.
module comp_reset_channel
  import comp_rst_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             comp_in,
  input  logic             ch_en,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] width_cfg,
  input  logic [CNT_W-1:0] holdoff_cfg,
  input  logic             retrig_en,
  input  logic             clr_ovr,
  output logic             rst_driver,
  output logic             busy,
  output logic             overrun
);

  logic             r_syncA;
  logic             r_syncB;
  logic             r_syncPrev;
  logic             r_edge;
  ch_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_hold;
  logic             r_rstN;
  logic             r_busy;
  logic             r_ovr;

  ch_state_t        w_nextState;
  logic [CNT_W-1:0] w_nextCnt;
  logic             w_latch;
  logic             w_ovrSet;
  logic [CNT_W-1:0] w_delayClamp;
  logic [CNT_W-1:0] w_widthClamp;

  assign w_delayClamp = CNT_W'(clampZero(CNT_W_MAX'(delay_cfg)));
  assign w_widthClamp = CNT_W'(clampZero(CNT_W_MAX'(width_cfg)));

  // Two-flop synchroniser followed by a registered one-cycle rising-edge strobe.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_syncA    <= 1'b0;
      r_syncB    <= 1'b0;
      r_syncPrev <= 1'b0;
      r_edge     <= 1'b0;
    end else begin
      r_syncA    <= comp_in;
      r_syncB    <= r_syncA;
      r_syncPrev <= r_syncB;
      r_edge     <= r_syncB & ~r_syncPrev;
    end
  end

  // Next-state logic: counter reloads on each state entry and counts down to
  // zero; the state advances on the cycle the counter reads zero.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_latch     = 1'b0;
    w_ovrSet    = 1'b0;
    if (!ch_en) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_edge) begin
            w_nextState = ST_DELAY;
            w_nextCnt   = w_delayClamp - CNT_W'(1);
            w_latch     = 1'b1;
          end
        end
        ST_DELAY: begin
          if (r_edge && retrig_en) begin
            w_nextCnt = r_delay - CNT_W'(1);
          end else begin
            w_ovrSet = r_edge;
            if (r_cnt == '0) begin
              w_nextState = ST_ACTIVE;
              w_nextCnt   = r_width - CNT_W'(1);
            end else begin
              w_nextCnt = r_cnt - CNT_W'(1);
            end
          end
        end
        ST_ACTIVE: begin
          w_ovrSet = r_edge;
          if (r_cnt == '0) begin
            if (r_hold == '0) begin
              w_nextState = ST_IDLE;
            end else begin
              w_nextState = ST_HOLDOFF;
              w_nextCnt   = r_hold - CNT_W'(1);
            end
          end else begin
            w_nextCnt = r_cnt - CNT_W'(1);
          end
        end
        ST_HOLDOFF: begin
          w_ovrSet = r_edge;
          if (r_cnt == '0) begin
            w_nextState = ST_IDLE;
          end else begin
            w_nextCnt = r_cnt - CNT_W'(1);
          end
        end
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  // State, counter, config latches and outputs; outputs are registered from
  // the next state so they change on the same edge as the state itself.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_delay <= '0;
      r_width <= '0;
      r_hold  <= '0;
      r_rstN  <= 1'b1;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_latch) begin
        r_delay <= w_delayClamp;
        r_width <= w_widthClamp;
        r_hold  <= holdoff_cfg;
      end
      r_rstN <= (w_nextState != ST_ACTIVE);
      r_busy <= (w_nextState != ST_IDLE);
      r_ovr  <= w_ovrSet | (r_ovr & ~clr_ovr);
    end
  end

  assign rst_driver = r_rstN;
  assign busy       = r_busy;
  assign overrun    = r_ovr;

endmodule

// File: rtl/comp_reset_sequencer.sv
// Multi-channel comparator reset sequencer: one independent channel per
// comparator input, sharing the timing configuration and overrun clear.
module comp_reset_sequencer
  import comp_rst_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  comp_out,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] width_cfg,
  input  logic [CNT_W-1:0] holdoff_cfg,
  input  logic             retrig_en,
  input  logic             clr_ovr,
  output logic [N_CH-1:0]  rst_driver,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  overrun
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    comp_reset_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .ref_clk     (ref_clk),
      .reset       (reset),
      .comp_in     (comp_out[g]),
      .ch_en       (ch_en[g]),
      .delay_cfg   (delay_cfg),
      .width_cfg   (width_cfg),
      .holdoff_cfg (holdoff_cfg),
      .retrig_en   (retrig_en),
      .clr_ovr     (clr_ovr),
      .rst_driver  (rst_driver[g]),
      .busy        (busy[g]),
      .overrun     (overrun[g])
    );
  end

endmodule

// File: tb/tb_comp_reset_sequencer.sv
// Directed bench for comp_reset_sequencer. Outputs are logged every falling
// edge indexed by a rising-edge cycle counter; scenarios compare the logged
// waveform against hand-derived cycle numbers.
module tb_comp_reset_sequencer;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 8;
  localparam int LOG_SZ = 8192;

  logic             ref_clk;
  logic             reset;
  logic [N_CH-1:0]  comp_out;
  logic [N_CH-1:0]  ch_en;
  logic [CNT_W-1:0] delay_cfg;
  logic [CNT_W-1:0] width_cfg;
  logic [CNT_W-1:0] holdoff_cfg;
  logic             retrig_en;
  logic             clr_ovr;
  logic [N_CH-1:0]  rst_driver;
  logic [N_CH-1:0]  busy;
  logic [N_CH-1:0]  overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [N_CH-1:0] rstLog  [0:LOG_SZ-1];
  logic [N_CH-1:0] busyLog [0:LOG_SZ-1];

  comp_reset_sequencer #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) dut (
    .ref_clk     (ref_clk),
    .reset       (reset),
    .comp_out    (comp_out),
    .ch_en       (ch_en),
    .delay_cfg   (delay_cfg),
    .width_cfg   (width_cfg),
    .holdoff_cfg (holdoff_cfg),
    .retrig_en   (retrig_en),
    .clr_ovr     (clr_ovr),
    .rst_driver  (rst_driver),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  // Cycle index advances on each rising edge.
  always @(posedge ref_clk) cyc <= cyc + 1;

  // Record the outputs mid-cycle for later waveform analysis.
  always @(negedge ref_clk) begin
    if (cyc < LOG_SZ) begin
      rstLog[cyc]  <= rst_driver;
      busyLog[cyc] <= busy;
    end
  end

  // Safety net so a stuck run still ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int firstLow(input int ch, input int a, input int b);
    for (int i = a; i < b; i++) if (rstLog[i][ch] == 1'b0) return i;
    return -1;
  endfunction

  function automatic int countLow(input int ch, input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) if (rstLog[i][ch] == 1'b0) n++;
    return n;
  endfunction

  function automatic int firstBusy(input int ch, input int a, input int b);
    for (int i = a; i < b; i++) if (busyLog[i][ch] == 1'b1) return i;
    return -1;
  endfunction

  function automatic int countBusy(input int ch, input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) if (busyLog[i][ch] == 1'b1) n++;
    return n;
  endfunction

  // Step falling edges until the cycle counter reaches t.
  task automatic goTo(input int t);
    while (cyc < t) @(negedge ref_clk);
  endtask

  // Raise comp_out bits at cycle t for three cycles; c0 returns t.
  task automatic risePulseAt(input logic [N_CH-1:0] mask, input int t, output int c0);
    goTo(t);
    comp_out = comp_out | mask;
    c0 = cyc;
    goTo(t + 3);
    comp_out = comp_out & ~mask;
  endtask

  task automatic applyConfig(input int d, input int w, input int h, input logic rt);
    delay_cfg   = CNT_W'(d);
    width_cfg   = CNT_W'(w);
    holdoff_cfg = CNT_W'(h);
    retrig_en   = rt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    goTo(cyc + 3);
    checks++;
    if (rst_driver !== 4'hF) begin errors++; $display("[TB] FAIL reset_rst: got %h expected F", rst_driver); end
    checks++;
    if (busy !== 4'h0) begin errors++; $display("[TB] FAIL reset_busy: got %h expected 0", busy); end
    checks++;
    if (overrun !== 4'h0) begin errors++; $display("[TB] FAIL reset_ovr: got %h expected 0", overrun); end
    reset = 1'b0;
    goTo(cyc + 3);
    checks++;
    if (rst_driver !== 4'hF) begin errors++; $display("[TB] FAIL idle_rst: got %h expected F", rst_driver); end
  endtask

  task automatic test_basic();
    int c0;
    applyConfig(20, 4, 0, 1'b0);
    risePulseAt(4'b0001, cyc + 1, c0);
    goTo(c0 + 45);
    checks++;
    if (firstLow(0, c0, c0 + 45) !== c0 + 24) begin errors++; $display("[TB] FAIL basic_start: got %0d expected %0d", firstLow(0, c0, c0 + 45), c0 + 24); end
    checks++;
    if (countLow(0, c0, c0 + 45) !== 4) begin errors++; $display("[TB] FAIL basic_width: got %0d expected 4", countLow(0, c0, c0 + 45)); end
    checks++;
    if (firstBusy(0, c0, c0 + 45) !== c0 + 4) begin errors++; $display("[TB] FAIL basic_busy_start: got %0d expected %0d", firstBusy(0, c0, c0 + 45), c0 + 4); end
    checks++;
    if (countBusy(0, c0, c0 + 45) !== 24) begin errors++; $display("[TB] FAIL basic_busy_len: got %0d expected 24", countBusy(0, c0, c0 + 45)); end
    for (int ch = 1; ch < N_CH; ch++) begin
      checks++;
      if (countLow(ch, c0, c0 + 45) + countBusy(ch, c0, c0 + 45) !== 0) begin
        errors++;
        $display("[TB] FAIL basic_other_ch%0d: got %0d active cycles expected 0", ch, countLow(ch, c0, c0 + 45) + countBusy(ch, c0, c0 + 45));
      end
    end
  endtask

  task automatic test_holdoff();
    int c0;
    int c1;
    applyConfig(5, 3, 10, 1'b0);
    risePulseAt(4'b0001, cyc + 1, c0);
    risePulseAt(4'b0001, c0 + 10, c1);
    goTo(c0 + 40);
    checks++;
    if (firstLow(0, c0, c0 + 40) !== c0 + 9) begin errors++; $display("[TB] FAIL hold_start: got %0d expected %0d", firstLow(0, c0, c0 + 40), c0 + 9); end
    checks++;
    if (countLow(0, c0, c0 + 40) !== 3) begin errors++; $display("[TB] FAIL hold_single_pulse: got %0d low cycles expected 3", countLow(0, c0, c0 + 40)); end
    checks++;
    if (countBusy(0, c0, c0 + 40) !== 18) begin errors++; $display("[TB] FAIL hold_busy_len: got %0d expected 18", countBusy(0, c0, c0 + 40)); end
    checks++;
    if (overrun !== 4'b0001) begin errors++; $display("[TB] FAIL hold_ovr: got %b expected 0001", overrun); end
    goTo(cyc + 1);
    clr_ovr = 1'b1;
    goTo(cyc + 1);
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 4'b0000) begin errors++; $display("[TB] FAIL hold_clr: got %b expected 0000", overrun); end
  endtask

  task automatic test_retrigger();
    int c0;
    int c1;
    applyConfig(10, 2, 0, 1'b1);
    risePulseAt(4'b0001, cyc + 1, c0);
    risePulseAt(4'b0001, c0 + 6, c1);
    goTo(c0 + 40);
    checks++;
    if (firstLow(0, c0, c0 + 40) !== c0 + 20) begin errors++; $display("[TB] FAIL retrig_start: got %0d expected %0d", firstLow(0, c0, c0 + 40), c0 + 20); end
    checks++;
    if (countLow(0, c0, c0 + 40) !== 2) begin errors++; $display("[TB] FAIL retrig_width: got %0d expected 2", countLow(0, c0, c0 + 40)); end
    checks++;
    if (overrun !== 4'b0000) begin errors++; $display("[TB] FAIL retrig_ovr: got %b expected 0000", overrun); end

    retrig_en = 1'b0;
    risePulseAt(4'b0001, cyc + 1, c0);
    risePulseAt(4'b0001, c0 + 6, c1);
    goTo(c0 + 40);
    checks++;
    if (firstLow(0, c0, c0 + 40) !== c0 + 14) begin errors++; $display("[TB] FAIL noretrig_start: got %0d expected %0d", firstLow(0, c0, c0 + 40), c0 + 14); end
    checks++;
    if (countLow(0, c0, c0 + 40) !== 2) begin errors++; $display("[TB] FAIL noretrig_width: got %0d expected 2", countLow(0, c0, c0 + 40)); end
    checks++;
    if (overrun !== 4'b0001) begin errors++; $display("[TB] FAIL noretrig_ovr: got %b expected 0001", overrun); end
    goTo(cyc + 1);
    clr_ovr = 1'b1;
    goTo(cyc + 1);
    clr_ovr = 1'b0;
  endtask

  task automatic test_zero_and_change();
    int c0;
    applyConfig(0, 0, 0, 1'b0);
    risePulseAt(4'b0001, cyc + 1, c0);
    goTo(c0 + 20);
    checks++;
    if (firstLow(0, c0, c0 + 20) !== c0 + 5) begin errors++; $display("[TB] FAIL zero_start: got %0d expected %0d", firstLow(0, c0, c0 + 20), c0 + 5); end
    checks++;
    if (countLow(0, c0, c0 + 20) !== 1) begin errors++; $display("[TB] FAIL zero_width: got %0d expected 1", countLow(0, c0, c0 + 20)); end
    checks++;
    if (countBusy(0, c0, c0 + 20) !== 2) begin errors++; $display("[TB] FAIL zero_busy: got %0d expected 2", countBusy(0, c0, c0 + 20)); end

    applyConfig(8, 4, 0, 1'b0);
    risePulseAt(4'b0001, cyc + 1, c0);
    goTo(c0 + 6);
    width_cfg = CNT_W'(9);
    delay_cfg = CNT_W'(30);
    goTo(c0 + 40);
    checks++;
    if (firstLow(0, c0, c0 + 40) !== c0 + 12) begin errors++; $display("[TB] FAIL cfgchg_start: got %0d expected %0d", firstLow(0, c0, c0 + 40), c0 + 12); end
    checks++;
    if (countLow(0, c0, c0 + 40) !== 4) begin errors++; $display("[TB] FAIL cfgchg_width: got %0d expected 4", countLow(0, c0, c0 + 40)); end
  endtask

  task automatic test_abort();
    int c0;
    int c1;
    applyConfig(3, 10, 0, 1'b0);
    risePulseAt(4'b0100, cyc + 1, c0);
    goTo(c0 + 9);
    checks++;
    if (rst_driver[2] !== 1'b0 || busy[2] !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre: got rst=%b busy=%b expected rst=0 busy=1", rst_driver[2], busy[2]); end
    ch_en = 4'b1011;
    goTo(c0 + 10);
    checks++;
    if (rst_driver[2] !== 1'b1 || busy[2] !== 1'b0) begin errors++; $display("[TB] FAIL abort_post: got rst=%b busy=%b expected rst=1 busy=0", rst_driver[2], busy[2]); end
    risePulseAt(4'b0100, c0 + 12, c1);
    goTo(c1 + 20);
    checks++;
    if (countBusy(2, c1, c1 + 20) !== 0) begin errors++; $display("[TB] FAIL disabled_busy: got %0d busy cycles expected 0", countBusy(2, c1, c1 + 20)); end
    checks++;
    if (overrun !== 4'b0000) begin errors++; $display("[TB] FAIL disabled_ovr: got %b expected 0000", overrun); end
    ch_en = 4'hF;
    goTo(cyc + 3);

    applyConfig(6, 10, 0, 1'b0);
    risePulseAt(4'hF, cyc + 1, c0);
    goTo(c0 + 5);
    comp_out = 4'hF;
    goTo(c0 + 8);
    comp_out = 4'h0;
    goTo(c0 + 12);
    checks++;
    if (rst_driver !== 4'h0 || busy !== 4'hF || overrun !== 4'hF) begin
      errors++;
      $display("[TB] FAIL midpulse_pre: got rst=%h busy=%h ovr=%h expected 0 F F", rst_driver, busy, overrun);
    end
    reset = 1'b1;
    goTo(c0 + 13);
    checks++;
    if (rst_driver !== 4'hF || busy !== 4'h0 || overrun !== 4'h0) begin
      errors++;
      $display("[TB] FAIL midpulse_reset: got rst=%h busy=%h ovr=%h expected F 0 0", rst_driver, busy, overrun);
    end
    reset = 1'b0;
    goTo(c0 + 16);
  endtask

  task automatic test_simultaneous();
    int c0;
    applyConfig(6, 3, 2, 1'b0);
    risePulseAt(4'hF, cyc + 1, c0);
    goTo(c0 + 6);
    comp_out[3] = 1'b1;
    goTo(c0 + 7);
    comp_out[1] = 1'b1;
    goTo(c0 + 9);
    comp_out[3] = 1'b0;
    goTo(c0 + 10);
    checks++;
    if (overrun !== 4'b1000) begin errors++; $display("[TB] FAIL sim_ovr_pre: got %b expected 1000", overrun); end
    clr_ovr = 1'b1;
    comp_out[1] = 1'b0;
    goTo(c0 + 11);
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 4'b0010) begin errors++; $display("[TB] FAIL sim_ovr_setwins: got %b expected 0010", overrun); end
    goTo(c0 + 30);
    for (int ch = 0; ch < N_CH; ch++) begin
      checks++;
      if (firstLow(ch, c0, c0 + 30) !== c0 + 10 || countLow(ch, c0, c0 + 30) !== 3 || countBusy(ch, c0, c0 + 30) !== 11) begin
        errors++;
        $display("[TB] FAIL sim_pulse_ch%0d: got start=%0d low=%0d busy=%0d expected start=%0d low=3 busy=11",
                 ch, firstLow(ch, c0, c0 + 30), countLow(ch, c0, c0 + 30), countBusy(ch, c0, c0 + 30), c0 + 10);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    comp_out    = '0;
    ch_en       = 4'hF;
    delay_cfg   = '0;
    width_cfg   = '0;
    holdoff_cfg = '0;
    retrig_en   = 1'b0;
    clr_ovr     = 1'b0;
    @(negedge ref_clk);
    test_reset();
    test_basic();
    test_holdoff();
    test_retrigger();
    test_zero_and_change();
    test_abort();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
